// File: rtl/smoother_pkg.sv
// smoother_pkg: shared states, widths and the clamp helper for vertex_smoother
package smoother_pkg;

    localparam int AXES  = 3;
    localparam int SAT_W = 128;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE      = 4'd0;
    localparam state_t S_CNT_REQ   = 4'd1;
    localparam state_t S_CNT_CAP   = 4'd2;
    localparam state_t S_CUR_FETCH = 4'd3;
    localparam state_t S_NBR_REQ   = 4'd4;
    localparam state_t S_NBR_CAP   = 4'd5;
    localparam state_t S_NBR_FETCH = 4'd6;
    localparam state_t S_WRITE     = 4'd7;
    localparam state_t S_DONE      = 4'd8;

    function automatic int acc_width(input int data_w, input int beta_w, input int max_nbr);
        return data_w + (1 << beta_w) + $clog2(max_nbr) + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                         input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo = ~hi;
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

endpackage

// File: rtl/vertex_accum.sv
// vertex_accum: three-lane wide accumulator with weighted init, add, and round+saturate readout
module vertex_accum
    import smoother_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int BETA_W  = 4,
    parameter int MAX_NBR = 10,
    parameter int CNT_W   = $clog2(MAX_NBR + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        init,
    input  logic                        add,
    input  logic [1:0]                  lane,
    input  logic [DATA_W-1:0]           din,
    input  logic [CNT_W-1:0]            cnt,
    input  logic [BETA_W-1:0]           shift,
    output logic [AXES-1:0][DATA_W-1:0] res
);

    localparam int ACC_W = acc_width(DATA_W, BETA_W, MAX_NBR);

    logic signed [ACC_W-1:0] acc_q [AXES];
    logic signed [ACC_W-1:0] acc_d [AXES];
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] cnt_s;
    logic signed [ACC_W-1:0] rnd;

    // Selected lane either starts as v*2^b - c*v or gains one neighbour coordinate
    always_comb begin
        ext   = ACC_W'($signed(din));
        cnt_s = ACC_W'({1'b0, cnt});
        for (int i = 0; i < AXES; i++)
            acc_d[i] = (init && lane == 2'(i)) ? (ext <<< shift) - ext * cnt_s :
                       (add  && lane == 2'(i)) ? acc_q[i] + ext : acc_q[i];
    end

    // Accumulator lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < AXES; i++) acc_q[i] <= '0;
        else
            acc_q <= acc_d;
    end

    // Add half an LSB, arithmetic shift (half rounds toward +inf), clamp to coordinate range
    always_comb begin
        rnd = (shift == '0) ? '0 : ACC_W'(1) << (shift - BETA_W'(1));
        for (int i = 0; i < AXES; i++)
            res[i] = DATA_W'(saturate(SAT_W'((acc_q[i] + rnd) >>> shift), DATA_W));
    end

endmodule

// File: rtl/vertex_smoother.sv
// vertex_smoother: per-vertex neighbour-weighted smoothing from OBJ/NBR RAMs into RES RAM
module vertex_smoother
    import smoother_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MAX_NBR = 10,
    parameter int BETA_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [BETA_W-1:0]     beta_shift,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  RAM_OBJ_EN,
    output logic [ADDR_W-1:0]     RAM_OBJ_A,
    input  logic [DATA_W-1:0]     RAM_OBJ_Do,
    output logic                  RAM_NBR_EN,
    output logic [ADDR_W-1:0]     RAM_NBR_A,
    input  logic [DATA_W-1:0]     RAM_NBR_Do,
    output logic                  RAM_RES_EN,
    output logic [DATA_W/8-1:0]   RAM_RES_WE,
    output logic [ADDR_W-1:0]     RAM_RES_A,
    output logic [DATA_W-1:0]     RAM_RES_Di
);

    localparam int CNT_W = $clog2(MAX_NBR + 1);

    state_t                  state_q, state_d;
    logic [31:0]             v_q, v_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        k_q, k_d;
    logic [ADDR_W-1:0]       u_q, u_d;
    logic [1:0]              ph_q, ph_d;
    logic                    err_q, err_d;
    logic                    bad_cnt;
    logic [ADDR_W-1:0]       row;
    logic [ADDR_W-1:0]       vbase;
    logic [ADDR_W-1:0]       ubase;
    logic                    fetch;
    logic                    obj_en;
    logic                    acc_init;
    logic                    acc_add;
    logic [AXES-1:0][DATA_W-1:0] res;

    // Sequencing through count read, own-vertex fetch, per-neighbour fetches and write-back
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        u_d     = u_q;
        ph_d    = ph_q;
        err_d   = err_q;
        bad_cnt = RAM_NBR_Do > DATA_W'(MAX_NBR - 1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    v_d     = '0;
                    state_d = (vertex_count == '0) ? S_DONE : S_CNT_REQ;
                end
            end
            S_CNT_REQ: state_d = S_CNT_CAP;
            S_CNT_CAP: begin
                cnt_d   = bad_cnt ? '0 : RAM_NBR_Do[CNT_W-1:0];
                err_d   = err_q | bad_cnt;
                k_d     = '0;
                ph_d    = '0;
                state_d = S_CUR_FETCH;
            end
            S_CUR_FETCH: begin
                ph_d = ph_q + 2'd1;
                if (ph_q == 2'd3) state_d = (cnt_q == '0) ? S_WRITE : S_NBR_REQ;
            end
            S_NBR_REQ: state_d = S_NBR_CAP;
            S_NBR_CAP: begin
                u_d     = RAM_NBR_Do[ADDR_W-1:0];
                state_d = S_NBR_FETCH;
            end
            S_NBR_FETCH: begin
                ph_d = ph_q + 2'd1;
                if (ph_q == 2'd3) begin
                    k_d     = k_q + CNT_W'(1);
                    state_d = (k_q + CNT_W'(1) == cnt_q) ? S_WRITE : S_NBR_REQ;
                end
            end
            S_WRITE: begin
                ph_d = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
                if (ph_q == 2'd2) begin
                    v_d     = v_q + 32'd1;
                    state_d = (v_q + 32'd1 == vertex_count) ? S_DONE : S_CNT_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and datapath registers; reset returns straight to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            u_q     <= '0;
            ph_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            u_q     <= u_d;
            ph_q    <= ph_d;
            err_q   <= err_d;
        end
    end

    // RAM ports decode from state only, so IDLE (and hence reset) drives every port to zero
    always_comb begin
        row        = v_q[ADDR_W-1:0] * ADDR_W'(MAX_NBR);
        vbase      = v_q[ADDR_W-1:0] * ADDR_W'(3);
        ubase      = u_q * ADDR_W'(3);
        fetch      = state_q == S_CUR_FETCH || state_q == S_NBR_FETCH;
        obj_en     = fetch && ph_q != 2'd3;
        acc_init   = state_q == S_CUR_FETCH && ph_q != 2'd0;
        acc_add    = state_q == S_NBR_FETCH && ph_q != 2'd0;
        RAM_NBR_EN = state_q == S_CNT_REQ || state_q == S_NBR_REQ;
        RAM_NBR_A  = (state_q == S_CNT_REQ) ? row :
                     (state_q == S_NBR_REQ) ? row + ADDR_W'(k_q) + ADDR_W'(1) : '0;
        RAM_OBJ_EN = obj_en;
        RAM_OBJ_A  = !obj_en ? '0 :
                     ((state_q == S_CUR_FETCH) ? vbase : ubase) + ADDR_W'(ph_q);
        RAM_RES_EN = state_q == S_WRITE;
        RAM_RES_WE = {(DATA_W/8){state_q == S_WRITE}};
        RAM_RES_A  = (state_q == S_WRITE) ? vbase + ADDR_W'(ph_q) : '0;
        RAM_RES_Di = (state_q != S_WRITE) ? '0 :
                     (ph_q == 2'd2) ? res[2] : (ph_q == 2'd1) ? res[1] : res[0];
    end

    assign busy = state_q != S_IDLE;
    assign done = state_q == S_DONE;
    assign err  = err_q;

    vertex_accum #(
        .DATA_W (DATA_W),
        .BETA_W (BETA_W),
        .MAX_NBR(MAX_NBR),
        .CNT_W  (CNT_W)
    ) u_accum (
        .clk  (clk),
        .rst_n(rst_n),
        .init (acc_init),
        .add  (acc_add),
        .lane (ph_q - 2'd1),
        .din  (RAM_OBJ_Do),
        .cnt  (cnt_q),
        .shift(beta_shift),
        .res  (res)
    );

endmodule

// File: tb/tb_vertex_smoother.sv
// tb_vertex_smoother: directed table vectors plus error, empty-job, busy-start and mid-job reset sequences
module tb_vertex_smoother;

    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    typedef struct {
        logic [2:0][31:0] v;
        logic [2:0][31:0] n0;
        logic [2:0][31:0] n1;
        logic [31:0]      c;
        logic [3:0]       b;
        logic [2:0][31:0] exp;
        int               cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] vertex_count = '0;
    logic [3:0]  beta_shift = '0;
    logic        busy, done, err;
    logic        RAM_OBJ_EN, RAM_NBR_EN, RAM_RES_EN;
    logic [8:0]  RAM_OBJ_A, RAM_NBR_A, RAM_RES_A;
    logic [31:0] RAM_OBJ_Do = '0;
    logic [31:0] RAM_NBR_Do = '0;
    logic [31:0] RAM_RES_Di;
    logic [3:0]  RAM_RES_WE;

    logic [31:0] obj_mem [512];
    logic [31:0] nbr_mem [512];
    logic [31:0] res_mem [512];
    logic        res_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl [7];

    always #5 clk = ~clk;

    vertex_smoother dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vertex_count(vertex_count),
        .beta_shift(beta_shift), .busy(busy), .done(done), .err(err),
        .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_OBJ_A(RAM_OBJ_A), .RAM_OBJ_Do(RAM_OBJ_Do),
        .RAM_NBR_EN(RAM_NBR_EN), .RAM_NBR_A(RAM_NBR_A), .RAM_NBR_Do(RAM_NBR_Do),
        .RAM_RES_EN(RAM_RES_EN), .RAM_RES_WE(RAM_RES_WE), .RAM_RES_A(RAM_RES_A),
        .RAM_RES_Di(RAM_RES_Di)
    );

    always @(posedge clk) begin
        if (RAM_OBJ_EN) RAM_OBJ_Do <= obj_mem[RAM_OBJ_A];
        if (RAM_NBR_EN) RAM_NBR_Do <= nbr_mem[RAM_NBR_A];
        if (res_clr)
            for (int i = 0; i < 512; i++) res_mem[i] <= SENT;
        else if (RAM_RES_EN && RAM_RES_WE == 4'hF)
            res_mem[RAM_RES_A] <= RAM_RES_Di;
    end

    function automatic logic [2:0][31:0] xyz(input int x, input int y, input int z);
        return {32'(z), 32'(y), 32'(x)};
    endfunction

    function automatic vec_t mk(input logic [2:0][31:0] v, input logic [2:0][31:0] n0,
                                input logic [2:0][31:0] n1, input int c, input int b,
                                input logic [2:0][31:0] exp, input int cyc);
        vec_t t;
        t.v = v; t.n0 = n0; t.n1 = n1; t.c = 32'(c); t.b = 4'(b); t.exp = exp; t.cyc = cyc;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic load_vec(input vec_t t);
        for (int a = 0; a < 3; a++) begin
            obj_mem[a]     = t.v[a];
            obj_mem[3 + a] = t.n0[a];
            obj_mem[6 + a] = t.n1[a];
        end
        nbr_mem[0] = t.c;
        nbr_mem[1] = 32'd1;
        nbr_mem[2] = 32'd2;
    endtask

    task automatic clear_res();
        @(negedge clk);
        res_clr = 1'b1;
        @(negedge clk);
        res_clr = 1'b0;
    endtask

    // Starts a job in the next IDLE cycle and counts cycles after the accepting edge until done
    task automatic run_job(input logic [31:0] vc, input logic [3:0] b,
                           output int cyc, output logic err1, output int en_cnt);
        vertex_count = vc;
        beta_shift   = b;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = -1;
        en_cnt = 0;
        err1 = 1'b0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (n == 1) err1 = err;
            if (RAM_OBJ_EN || RAM_NBR_EN || RAM_RES_EN || RAM_RES_WE != 4'h0) en_cnt++;
            if (done) begin
                cyc = n;
                break;
            end
        end
        if (cyc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL job_timeout: got no done, want done within 2000 cycles");
        end
    endtask

    initial begin
        int   cyc, enc, dn;
        logic e1;

        tbl[0] = mk(xyz(100, -200, 300), xyz(0, 0, 0), xyz(0, 0, 0), 0, 4,
                    xyz(100, -200, 300), 10);
        tbl[1] = mk(xyz(160, 0, -16), xyz(16, 32, 48), xyz(0, 0, 0), 2, 4,
                    xyz(141, 2, -11), 22);
        tbl[2] = mk(xyz(32'hC000_0000, 0, 5), xyz(32'h7FFF_FFFF, 1, 2), xyz(32'h7FFF_FFFF, 3, -4), 2, 0,
                    xyz(32'h7FFF_FFFF, 4, -7), 22);
        tbl[3] = mk(xyz(32'h4000_0000, 7, -1), xyz(32'h8000_0000, 1, 0), xyz(32'h8000_0000, 2, 0), 2, 0,
                    xyz(32'h8000_0000, -4, 1), 22);
        tbl[4] = mk(xyz(3, -3, 10), xyz(4, -4, -11), xyz(0, 0, 0), 1, 1,
                    xyz(4, -3, 0), 16);
        tbl[5] = mk(xyz(0, -1, 1), xyz(1, 0, -2), xyz(0, 0, 0), 1, 1,
                    xyz(1, 0, 0), 16);
        tbl[6] = mk(xyz(32'h7FFF_FFFF, 32'h8000_0000, -1), xyz(0, 0, 0), xyz(0, 0, 0), 0, 15,
                    xyz(32'h7FFF_FFFF, 32'h8000_0000, -1), 10);

        for (int i = 0; i < 512; i++) begin
            obj_mem[i] = '0;
            nbr_mem[i] = '0;
        end

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_en_we", {26'd0, RAM_OBJ_EN, RAM_NBR_EN, RAM_RES_EN, 3'd0} | 32'(RAM_RES_WE), 32'd0);
        check("rst_addr", {5'd0, RAM_OBJ_A, RAM_NBR_A, RAM_RES_A}, 32'd0);
        check("rst_di", RAM_RES_Di, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            load_vec(tbl[i]);
            clear_res();
            run_job(32'd1, tbl[i].b, cyc, e1, enc);
            for (int a = 0; a < 3; a++)
                check($sformatf("vec%0d_res%0d", i, a), res_mem[a], tbl[i].exp[a]);
            check($sformatf("vec%0d_done_cycle", i), 32'(cyc), 32'(tbl[i].cyc));
            check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
        end

        // Overlong neighbour list on vertex 0, normal vertex 1 using vertex 0 as its neighbour
        obj_mem[0] = 32'd7;  obj_mem[1] = 32'd8;  obj_mem[2] = 32'd9;
        obj_mem[3] = 32'd4;  obj_mem[4] = 32'd8;  obj_mem[5] = -32'sd12;
        nbr_mem[0] = 32'd10;
        nbr_mem[10] = 32'd1;
        nbr_mem[11] = 32'd0;
        clear_res();
        run_job(32'd2, 4'd2, cyc, e1, enc);
        check("errjob_done_cycle", 32'(cyc), 32'd25);
        check("errjob_err", 32'(err), 32'd1);
        check("errjob_v0x", res_mem[0], 32'd7);
        check("errjob_v0y", res_mem[1], 32'd8);
        check("errjob_v0z", res_mem[2], 32'd9);
        check("errjob_v1x", res_mem[3], 32'd5);
        check("errjob_v1y", res_mem[4], 32'd8);
        check("errjob_v1z", res_mem[5], -32'sd7);

        // Back-to-back: start in the IDLE cycle right after DONE; err must clear on acceptance
        load_vec(tbl[0]);
        run_job(32'd1, 4'd4, cyc, e1, enc);
        check("b2b_err_cleared", 32'(e1), 32'd0);
        check("b2b_done_cycle", 32'(cyc), 32'd10);
        check("b2b_res_y", res_mem[1], 32'hFFFF_FF38);

        // Empty job: immediate done, no RAM activity
        run_job(32'd0, 4'd4, cyc, e1, enc);
        check("empty_done_cycle", 32'(cyc), 32'd1);
        check("empty_en_cycles", 32'(enc), 32'd0);

        // start held high while busy must not restart or queue a second job
        load_vec(tbl[0]);
        clear_res();
        vertex_count = 32'd1;
        beta_shift = 4'd4;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        start = 1'b0;
        dn = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("busy_start_dones", 32'(dn), 32'd1);
        check("busy_start_res_z", res_mem[2], 32'd300);

        // Reset during the second write cycle of a c=2 job, then rerun it
        load_vec(tbl[1]);
        clear_res();
        vertex_count = 32'd1;
        beta_shift = 4'd4;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_we_before", 32'(RAM_RES_WE), 32'hF);
        check("midrst_addr_before", 32'(RAM_RES_A), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(RAM_RES_WE), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_first_written", res_mem[0], 32'd141);
        check("midrst_second_unwritten", res_mem[1], SENT);
        run_job(32'd1, 4'd4, cyc, e1, enc);
        check("rerun_done_cycle", 32'(cyc), 32'd22);
        check("rerun_x", res_mem[0], 32'd141);
        check("rerun_y", res_mem[1], 32'd2);
        check("rerun_z", res_mem[2], -32'sd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
